// File: rtl/bf_uart_tx_if.sv
// COUT handshake and serial line between the brainfuck CPU's uart-connect
// ports and the transmitter; the CPU side is master, the transmitter slave.
interface bf_uart_tx_if;
    logic [7:0] tx_data;
    logic       flag_output_begin;
    logic       flag_output_active;
    logic       tx_done;
    logic       uart_txd;

    modport master (
        output tx_data,
        output flag_output_begin,
        input  flag_output_active,
        input  tx_done,
        input  uart_txd
    );

    modport slave (
        input  tx_data,
        input  flag_output_begin,
        output flag_output_active,
        output tx_done,
        output uart_txd
    );
endinterface

// File: rtl/bf_uart_tx.sv
// UART transmitter for the CPU's '.' instruction: latches the data-memory byte
// on flag_output_begin and sends one 8-bit frame with optional parity.
module bf_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            rst,
    bf_uart_tx_if.slave     bus
);
    localparam int              CNT_W     = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);
    localparam bit              PAR_EN    = (PARITY == 1) || (PARITY == 2);
    localparam bit              PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] baud_cnt, baud_nxt;
    logic [2:0]       bit_idx, idx_nxt;
    logic [7:0]       shreg, sh_nxt;
    logic             par_bit, par_nxt;
    logic             txd_q, txd_nxt;
    logic             active_q, active_nxt;
    logic             done_q, done_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            txd_q    <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= idx_nxt;
            shreg    <= sh_nxt;
            par_bit  <= par_nxt;
            txd_q    <= txd_nxt;
            active_q <= active_nxt;
            done_q   <= done_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        idx_nxt   = bit_idx;
        sh_nxt    = shreg;
        par_nxt   = par_bit;
        done_nxt  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (bus.flag_output_begin) begin
                    sh_nxt    = bus.tx_data;
                    par_nxt   = PAR_ODD ? ~^bus.tx_data : ^bus.tx_data;
                    idx_nxt   = 3'd0;
                    baud_nxt  = '0;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_nxt  = '0;
                    state_nxt = S_DATA;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_nxt = '0;
                    sh_nxt   = shreg >> 1;
                    idx_nxt  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state_nxt = PAR_EN ? S_PARITY : S_STOP;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_nxt  = '0;
                    state_nxt = S_STOP;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            S_STOP: begin
                // One long stop interval covers both stop bits when STOP_BITS=2.
                if (baud_cnt == STOP_LAST) begin
                    baud_nxt  = '0;
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Line level is derived from the upcoming state so uart_txd stays registered.
        unique case (state_nxt)
            S_START:  txd_nxt = 1'b0;
            S_DATA:   txd_nxt = sh_nxt[0];
            S_PARITY: txd_nxt = par_nxt;
            default:  txd_nxt = 1'b1;
        endcase
        active_nxt = (state_nxt != S_IDLE);
    end

    assign bus.uart_txd           = txd_q;
    assign bus.flag_output_active = active_q;
    assign bus.tx_done            = done_q;
endmodule

// File: tb/tb_bf_uart_tx.sv
// Scoreboard bench for bf_uart_tx: four instances cover no parity, even, odd
// and two stop bits; a per-instance monitor rebuilds each frame from the byte.
module tb_bf_uart_tx;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d_drv [4];
    logic [3:0] b_drv;
    logic [3:0] act_s, done_s, txd_s;
    logic [7:0] exp_q [4][$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        localparam int PAR = (g == 1) ? 2 : (g == 2) ? 1 : 0;
        localparam int SB  = (g == 3) ? 2 : 1;

        bf_uart_tx_if ifc ();
        assign ifc.tx_data           = d_drv[g];
        assign ifc.flag_output_begin = b_drv[g];
        assign act_s[g]              = ifc.flag_output_active;
        assign done_s[g]             = ifc.tx_done;
        assign txd_s[g]              = ifc.uart_txd;

        bf_uart_tx #(
            .CLKS_PER_BIT(CPB),
            .PARITY      (PAR),
            .STOP_BITS   (SB)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(ifc)
        );

        logic        in_frame = 1'b0;
        logic [11:0] exp_bits;
        logic [7:0]  d;
        int          cyc, flen, bad, nb, ones;

        // Expected frame: start 0, data LSB first, optional parity, stop 1s.
        always @(negedge clk) begin
            if (rst) begin
                in_frame = 1'b0;
            end else begin
                if (in_frame && cyc == flen) begin
                    check($sformatf("dut%0d_frame_wave", g), bad, 0);
                    check($sformatf("dut%0d_frame_end", g), {act_s[g], done_s[g]}, 2'b01);
                    in_frame = 1'b0;
                end else if (!in_frame) begin
                    if (act_s[g]) begin
                        check($sformatf("dut%0d_frame_expected", g), int'(exp_q[g].size() > 0), 1);
                        d = (exp_q[g].size() > 0) ? exp_q[g].pop_front() : 8'h00;
                        ones = $countones(d);
                        exp_bits = '1;
                        exp_bits[0] = 1'b0;
                        for (int i = 0; i < 8; i++) exp_bits[1+i] = d[i];
                        nb = 9;
                        if (PAR == 1 || PAR == 2) begin
                            exp_bits[nb] = (PAR == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
                            nb++;
                        end
                        nb += SB;
                        flen = nb * CPB;
                        cyc = 0;
                        bad = 0;
                        in_frame = 1'b1;
                    end else begin
                        check($sformatf("dut%0d_idle_line", g), {txd_s[g], done_s[g]}, 2'b10);
                    end
                end
                if (in_frame) begin
                    if (act_s[g] !== 1'b1 || done_s[g] !== 1'b0 || txd_s[g] !== exp_bits[cyc / CPB])
                        bad++;
                    cyc++;
                end
            end
        end
    end

    task automatic send(input int i, input logic [7:0] d, input bit accept);
        d_drv[i] = d;
        b_drv[i] = 1'b1;
        if (accept) exp_q[i].push_back(d);
        @(negedge clk);
        b_drv[i] = 1'b0;
        d_drv[i] = 8'($urandom);
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while ((act_s[i] || exp_q[i].size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("dut%0d_wait_idle", i), int'(n < 3000), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int offs [4] = '{5, 20, 39, 40};
        int cur;
        logic [7:0] hi [2] = '{8'h48, 8'h69};

        rst   = 1'b1;
        b_drv = '0;
        for (int i = 0; i < 4; i++) d_drv[i] = 8'h00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            check($sformatf("dut%0d_reset_state", i), {txd_s[i], act_s[i], done_s[i]}, 3'b100);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed frames on each parameter set.
        send(0, 8'h41, 1'b1);
        wait_idle(0);
        send(1, 8'h07, 1'b1);
        send(2, 8'h07, 1'b1);
        send(3, 8'hFF, 1'b1);
        wait_idle(1);
        wait_idle(2);
        wait_idle(3);

        // Begin pulses mid-frame and on the final stop cycle are dropped.
        send(0, 8'h41, 1'b1);
        cur = 1;
        for (int k = 0; k < 4; k++) begin
            repeat (offs[k] - cur) @(negedge clk);
            send(0, 8'($urandom), 1'b0);
            cur = offs[k] + 1;
        end
        wait_idle(0);
        repeat (20) @(negedge clk);

        // Back-to-back: begin on the cycle tx_done is high.
        send(0, 8'hA5, 1'b1);
        n = 0;
        while (!done_s[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done_seen", int'(n < 200), 1);
        send(0, 8'h5A, 1'b1);
        wait_idle(0);

        // Asynchronous reset in the middle of a frame.
        send(0, 8'h55, 1'b1);
        repeat (13) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_midframe_outputs", {txd_s[0], act_s[0], done_s[0]}, 3'b100);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_queue_consumed", exp_q[0].size(), 0);
        send(0, 8'h3C, 1'b1);
        wait_idle(0);

        // CPU loop printing "Hi": poll busy before each new byte.
        for (int c = 0; c < 2; c++) begin
            n = 0;
            while (act_s[0] && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("cpu_wait_not_busy", int'(n < 200), 1);
            send(0, hi[c], 1'b1);
            repeat (3) @(negedge clk);
            check("cpu_sees_busy", act_s[0], 1);
        end
        wait_idle(0);

        // Random bytes on all instances concurrently.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) send(i, 8'($urandom), 1'b1);
            for (int i = 0; i < 4; i++) wait_idle(i);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++)
            check($sformatf("dut%0d_queue_empty", i), exp_q[i].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
